// File: rtl/bus_cycle_ctrl.sv
// Purpose : 8088 bus-cycle sequencer. Latches the multiplexed address on ALE, decodes it
//           into one of four active-low chip selects (MEM0, MEM1, IO0, IO1), inserts
//           per-region wait states by holding READY low, and pulses BUS_ERR on malformed
//           cycles.
// Latency : all outputs are registered. CS_N/ADDR_LAT appear 1 cycle after ALE is sampled,
//           and READY drops 1 cycle after the strobe is sampled.
// Backpressure: READY low = wait state. An early strobe release aborts the cycle.
// Ports   : CLK, RESET (sync, active-high) | ALE, IOM, RD/WR (active-low), Address[19:0]
//           -> ADDR_LAT[19:0], CS_N[3:0] (bit0 MEM0, bit1 MEM1, bit2 IO0, bit3 IO1),
//              READY, BUS_ERR (1-cycle pulse), BUSY (state != IDLE)
module bus_cycle_ctrl #(
    parameter int MEM0_WS     = 0,
    parameter int MEM1_WS     = 1,
    parameter int IO0_WS      = 2,
    parameter int IO1_WS      = 3,
    parameter int STB_TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic        RD,
    input  logic        WR,
    input  logic [19:0] Address,
    output logic [19:0] ADDR_LAT,
    output logic [3:0]  CS_N,
    output logic        READY,
    output logic        BUS_ERR,
    output logic        BUSY
);

    localparam int TO_W = $clog2(STB_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(STB_TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ADDR = 5'b00010,
        S_WAIT = 5'b00100,
        S_XFER = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    state_t          r_state,    w_state;
    logic [1:0]      r_region,   w_region;
    logic [2:0]      r_wait_cnt, w_wait_cnt;
    logic [TO_W-1:0] r_to_cnt,   w_to_cnt;
    logic [19:0]     r_addr_lat, w_addr_lat;
    logic [3:0]      r_cs_n,     w_cs_n;
    logic            r_ready,    w_ready;
    logic            r_bus_err,  w_bus_err;
    logic            r_busy,     w_busy;

    logic            w_stb_one, w_stb_both, w_stb_none;
    logic [1:0]      w_dec_region;
    logic            w_dec_ok;
    logic [2:0]      w_ws_sel;

    // Strobes are active-low; exactly one low is a legal transfer request.
    assign w_stb_one  = (~RD) ^ (~WR);
    assign w_stb_both = ~RD & ~WR;
    assign w_stb_none = RD & WR;

    // Region index doubles as the CS_N bit position.
    always_comb begin
        w_dec_ok     = 1'b1;
        w_dec_region = 2'd0;
        if (!IOM) begin
            w_dec_region = Address[19] ? 2'd1 : 2'd0;
        end else if (Address[19:16] == 4'h0) begin
            w_dec_region = Address[15] ? 2'd3 : 2'd2;
        end else begin
            w_dec_ok = 1'b0;
        end
    end

    always_comb begin
        case (r_region)
            2'd0:    w_ws_sel = 3'(MEM0_WS);
            2'd1:    w_ws_sel = 3'(MEM1_WS);
            2'd2:    w_ws_sel = 3'(IO0_WS);
            default: w_ws_sel = 3'(IO1_WS);
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_region   = r_region;
        w_wait_cnt = r_wait_cnt;
        w_to_cnt   = r_to_cnt;
        w_addr_lat = r_addr_lat;
        w_cs_n     = r_cs_n;
        w_ready    = r_ready;
        w_bus_err  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cs_n  = 4'hF;
                w_ready = 1'b1;
                if (ALE) begin
                    w_addr_lat = Address;
                    if (w_dec_ok) begin
                        w_region = w_dec_region;
                        w_cs_n   = ~(4'b0001 << w_dec_region);
                        w_to_cnt = '0;
                        w_state  = S_ADDR;
                    end else begin
                        w_bus_err = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (w_stb_both) begin
                    w_bus_err = 1'b1;
                    w_cs_n    = 4'hF;
                    w_to_cnt  = '0;
                    w_state   = S_IDLE;
                end else if (w_stb_one) begin
                    w_to_cnt   = '0;
                    w_wait_cnt = w_ws_sel;
                    if (w_ws_sel == 3'd0) begin
                        w_ready = 1'b1;
                        w_state = S_XFER;
                    end else begin
                        w_ready = 1'b0;
                        w_state = S_WAIT;
                    end
                end else if (r_to_cnt >= TO_LAST) begin
                    w_bus_err = 1'b1;
                    w_cs_n    = 4'hF;
                    w_to_cnt  = '0;
                    w_state   = S_IDLE;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (w_stb_none) begin
                    // Strobe withdrawn before the wait completed: quiet abort.
                    w_ready    = 1'b1;
                    w_cs_n     = 4'hF;
                    w_wait_cnt = 3'd0;
                    w_state    = S_IDLE;
                end else if (r_wait_cnt <= 3'd1) begin
                    // Counter saturates at 0; READY rises on the edge it would hit 0.
                    w_wait_cnt = 3'd0;
                    w_ready    = 1'b1;
                    w_state    = S_XFER;
                end else begin
                    w_wait_cnt = r_wait_cnt - 3'd1;
                end
            end
            S_XFER: begin
                w_ready = 1'b1;
                if (w_stb_none) begin
                    w_cs_n  = 4'hF;
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                // Turnaround cycle; ALE here is deliberately ignored.
                w_cs_n  = 4'hF;
                w_ready = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_cs_n  = 4'hF;
                w_ready = 1'b1;
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_region   <= 2'd0;
            r_wait_cnt <= 3'd0;
            r_to_cnt   <= '0;
            r_addr_lat <= 20'h0;
            r_cs_n     <= 4'hF;
            r_ready    <= 1'b1;
            r_bus_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_region   <= w_region;
            r_wait_cnt <= w_wait_cnt;
            r_to_cnt   <= w_to_cnt;
            r_addr_lat <= w_addr_lat;
            r_cs_n     <= w_cs_n;
            r_ready    <= w_ready;
            r_bus_err  <= w_bus_err;
            r_busy     <= w_busy;
        end
    end

    assign ADDR_LAT = r_addr_lat;
    assign CS_N     = r_cs_n;
    assign READY    = r_ready;
    assign BUS_ERR  = r_bus_err;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Purpose : self-checking bench for bus_cycle_ctrl (default parameters).
// Latency : each vector drives inputs for one edge and checks the registered outputs after it.
// Backpressure: n/a (bench).
module tb_bus_cycle_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, ALE, IOM, RD, WR;
    logic [19:0] Address;
    logic [19:0] ADDR_LAT;
    logic [3:0]  CS_N;
    logic        READY, BUS_ERR, BUSY;

    always #5 CLK = ~CLK;

    bus_cycle_ctrl dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ALE      (ALE),
        .IOM      (IOM),
        .RD       (RD),
        .WR       (WR),
        .Address  (Address),
        .ADDR_LAT (ADDR_LAT),
        .CS_N     (CS_N),
        .READY    (READY),
        .BUS_ERR  (BUS_ERR),
        .BUSY     (BUSY)
    );

    typedef struct {
        logic        rst, ale, iom, rd, wr;
        logic [19:0] addr;
        logic [3:0]  cs_n;
        logic        ready, err, busy;
        logic [19:0] lat;
    } vec_t;

    typedef struct {
        logic [3:0]  cs_n;
        logic        ready, err, busy;
        logic [19:0] lat;
        int          id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vid   = 0;

    task automatic add(input logic rst, input logic ale, input logic iom, input logic rd,
                       input logic wr, input logic [19:0] addr, input logic [3:0] cs,
                       input logic rdy, input logic err, input logic busy,
                       input logic [19:0] lat);
        vec_t v;
        v.rst = rst; v.ale = ale; v.iom = iom; v.rd = rd; v.wr = wr; v.addr = addr;
        v.cs_n = cs; v.ready = rdy; v.err = err; v.busy = busy; v.lat = lat;
        tbl.push_back(v);
    endtask

    task automatic check();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry for DUT output");
        end else begin
            e = sb.pop_front();
            if ({CS_N, READY, BUS_ERR, BUSY, ADDR_LAT} !==
                {e.cs_n, e.ready, e.err, e.busy, e.lat}) begin
                n_bad++;
                $display("FAIL vec%0d: got cs_n=%h ready=%b err=%b busy=%b lat=%h, want cs_n=%h ready=%b err=%b busy=%b lat=%h",
                         e.id, CS_N, READY, BUS_ERR, BUSY, ADDR_LAT,
                         e.cs_n, e.ready, e.err, e.busy, e.lat);
            end
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge CLK);
        RESET = v.rst; ALE = v.ale; IOM = v.iom; RD = v.rd; WR = v.wr; Address = v.addr;
        e.cs_n = v.cs_n; e.ready = v.ready; e.err = v.err; e.busy = v.busy; e.lat = v.lat;
        e.id = vid;
        vid++;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check();
    endtask

    task automatic run1(input logic rst, input logic ale, input logic iom, input logic rd,
                        input logic wr, input logic [19:0] addr, input logic [3:0] cs,
                        input logic rdy, input logic err, input logic busy,
                        input logic [19:0] lat);
        vec_t v;
        v.rst = rst; v.ale = ale; v.iom = iom; v.rd = rd; v.wr = wr; v.addr = addr;
        v.cs_n = cs; v.ready = rdy; v.err = err; v.busy = busy; v.lat = lat;
        step(v);
    endtask

    initial begin
        RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; Address = 20'h0;

        //   rst ale iom rd wr addr      cs    rdy err busy lat
        // reset state
        add(1, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00000);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00000);
        // memory read, MEM0, zero waits
        add(0, 1, 0, 1, 1, 20'h01234, 4'hE, 1, 0, 1, 20'h01234);
        add(0, 0, 0, 0, 1, 20'h00000, 4'hE, 1, 0, 1, 20'h01234);
        add(0, 0, 0, 0, 1, 20'h00000, 4'hE, 1, 0, 1, 20'h01234);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h01234);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h01234);
        // memory write, MEM1, one wait
        add(0, 1, 0, 1, 1, 20'h80010, 4'hD, 1, 0, 1, 20'h80010);
        add(0, 0, 0, 1, 0, 20'h00000, 4'hD, 0, 0, 1, 20'h80010);
        add(0, 0, 0, 1, 0, 20'h00000, 4'hD, 1, 0, 1, 20'h80010);
        add(0, 0, 0, 1, 0, 20'h00000, 4'hD, 1, 0, 1, 20'h80010);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h80010);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h80010);
        // IO0 read, two waits
        add(0, 1, 1, 1, 1, 20'h00040, 4'hB, 1, 0, 1, 20'h00040);
        add(0, 0, 0, 0, 1, 20'h00000, 4'hB, 0, 0, 1, 20'h00040);
        add(0, 0, 0, 0, 1, 20'h00000, 4'hB, 0, 0, 1, 20'h00040);
        add(0, 0, 0, 0, 1, 20'h00000, 4'hB, 1, 0, 1, 20'h00040);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h00040);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00040);
        // IO1 read, three waits, ALE during XFER ignored
        add(0, 1, 1, 1, 1, 20'h08000, 4'h7, 1, 0, 1, 20'h08000);
        add(0, 0, 0, 0, 1, 20'h00000, 4'h7, 0, 0, 1, 20'h08000);
        add(0, 0, 0, 0, 1, 20'h00000, 4'h7, 0, 0, 1, 20'h08000);
        add(0, 0, 0, 0, 1, 20'h00000, 4'h7, 0, 0, 1, 20'h08000);
        add(0, 0, 0, 0, 1, 20'h00000, 4'h7, 1, 0, 1, 20'h08000);
        add(0, 1, 0, 0, 1, 20'h12345, 4'h7, 1, 0, 1, 20'h08000);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h08000);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h08000);
        // IO decode error
        add(0, 1, 1, 1, 1, 20'h10000, 4'hF, 1, 1, 0, 20'h10000);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h10000);
        // RD and WR low together in ADDR
        add(0, 1, 0, 1, 1, 20'h00100, 4'hE, 1, 0, 1, 20'h00100);
        add(0, 0, 0, 0, 0, 20'h00000, 4'hF, 1, 1, 0, 20'h00100);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00100);
        // IO1 early abort mid-WAIT
        add(0, 1, 1, 1, 1, 20'h08004, 4'h7, 1, 0, 1, 20'h08004);
        add(0, 0, 0, 0, 1, 20'h00000, 4'h7, 0, 0, 1, 20'h08004);
        add(0, 0, 0, 0, 1, 20'h00000, 4'h7, 0, 0, 1, 20'h08004);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h08004);
        add(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h08004);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Back-to-back reads: ALE in DONE ignored, second CS only after DONE.
        run1(0, 1, 0, 1, 1, 20'h00200, 4'hE, 1, 0, 1, 20'h00200);
        run1(0, 0, 0, 0, 1, 20'h00000, 4'hE, 1, 0, 1, 20'h00200);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h00200);
        run1(0, 1, 0, 1, 1, 20'h00300, 4'hF, 1, 0, 0, 20'h00200);
        run1(0, 1, 0, 1, 1, 20'h00300, 4'hE, 1, 0, 1, 20'h00300);
        run1(0, 0, 0, 0, 1, 20'h00000, 4'hE, 1, 0, 1, 20'h00300);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h00300);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00300);

        // Strobe timeout: 7 quiet cycles in ADDR are fine, the 8th errors.
        run1(0, 1, 0, 1, 1, 20'h00400, 4'hE, 1, 0, 1, 20'h00400);
        for (int k = 0; k < 7; k++)
            run1(0, 0, 0, 1, 1, 20'h00000, 4'hE, 1, 0, 1, 20'h00400);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 1, 0, 20'h00400);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00400);

        // Reset during WAIT, then a fresh one-wait cycle to show counters cleared.
        run1(0, 1, 1, 1, 1, 20'h08000, 4'h7, 1, 0, 1, 20'h08000);
        run1(0, 0, 0, 0, 1, 20'h00000, 4'h7, 0, 0, 1, 20'h08000);
        run1(1, 0, 0, 0, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00000);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h00000);
        run1(0, 1, 0, 1, 1, 20'h80010, 4'hD, 1, 0, 1, 20'h80010);
        run1(0, 0, 0, 0, 1, 20'h00000, 4'hD, 0, 0, 1, 20'h80010);
        run1(0, 0, 0, 0, 1, 20'h00000, 4'hD, 1, 0, 1, 20'h80010);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 1, 20'h80010);
        run1(0, 0, 0, 1, 1, 20'h00000, 4'hF, 1, 0, 0, 20'h80010);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
